// File: rtl/if_stage_pkg.sv
// Shared types and constants for the fetch stage and its neighbours.
package if_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  // Pending-redirect FSM encoding kept as plain constants for legacy tools.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  // Hazard flag shared with the ID/EX register.
  typedef enum logic {
    HZ_NORMAL = 1'b0,
    HZ_FLUSH  = 1'b1
  } hazard_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
    logic [31:0] pc_plus_8;
  } if_id_payload_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and imem.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID interstage register; bubble takes priority over hold.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           hold,
  input  hazard_t        flag,
  input  if_id_payload_t d,
  output if_id_payload_t q,
  output logic           valid
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q.instr     <= NOP_INSTR;
      q.pc_plus_4 <= '0;
      q.pc_plus_8 <= '0;
      valid       <= 1'b0;
    end else if (flag == HZ_FLUSH) begin
      q.instr     <= NOP_INSTR;
      q.pc_plus_4 <= '0;
      q.pc_plus_8 <= '0;
      valid       <= 1'b0;
    end else if (!hold) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC, next-PC selection, pending-redirect FSM and IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_IF,
  input  logic        flush_IF_ID,
  input  logic        EX_branch_taken,
  input  logic [31:0] EX_branch_target,
  input  logic        ID_jump,
  input  logic [31:0] ID_jump_target,
  if_stage_if.master  imem,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_PC_plus_4,
  output logic [31:0] IF_ID_PC_plus_8,
  output logic        IF_ID_valid
);

  logic [0:0]     state, state_next;
  logic [31:0]    pend_target, pend_next;
  logic [31:0]    pc_next, pc_plus_4, pc_plus_8;
  logic [31:0]    redir_target;
  logic           redirect;
  logic           hold;
  hazard_t        flag;
  if_id_payload_t d, q;

  // A stalled ID jump re-presents next cycle, so it is not a redirect yet.
  assign redirect     = EX_branch_taken | (ID_jump & ~stall_IF);
  assign redir_target = EX_branch_taken ? EX_branch_target : ID_jump_target;
  assign pc_plus_4    = PC + 32'd4;
  assign pc_plus_8    = PC + 32'd8;
  assign imem.imem_addr = PC;

  always_comb begin
    pc_next    = PC;
    state_next = state;
    pend_next  = pend_target;
    hold       = 1'b0;
    flag       = HZ_NORMAL;
    case (state)
      IDLE: begin
        if (imem.imem_ready) begin
          if (redirect) begin
            pc_next = redir_target;
            flag    = HZ_FLUSH;
          end else if (flush_IF_ID) begin
            pc_next = pc_plus_4;
            flag    = HZ_FLUSH;
          end else if (stall_IF) begin
            hold = 1'b1;
          end else begin
            pc_next = pc_plus_4;
          end
        end else if (redirect) begin
          pend_next  = redir_target;
          flag       = HZ_FLUSH;
          state_next = PEND;
        end else if (stall_IF && !flush_IF_ID) begin
          hold = 1'b1;
        end else begin
          flag = HZ_FLUSH;
        end
      end
      default: begin
        // The word returned in PEND belongs to the abandoned path.
        flag = HZ_FLUSH;
        if (redirect) pend_next = redir_target;
        if (imem.imem_ready) begin
          pc_next    = redirect ? redir_target : pend_target;
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      PC          <= RESET_PC;
      state       <= IDLE;
      pend_target <= '0;
    end else begin
      PC          <= pc_next;
      state       <= state_next;
      pend_target <= pend_next;
    end
  end

  assign d.instr     = imem.imem_rdata;
  assign d.pc_plus_4 = pc_plus_4;
  assign d.pc_plus_8 = pc_plus_8;

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .flag  (flag),
    .d     (d),
    .q     (q),
    .valid (IF_ID_valid)
  );

  assign IF_ID_instr     = q.instr;
  assign IF_ID_PC_plus_4 = q.pc_plus_4;
  assign IF_ID_PC_plus_8 = q.pc_plus_8;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expectations queued per driven cycle, popped after the edge.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_IF, flush_IF_ID;
  logic        EX_branch_taken, ID_jump;
  logic [31:0] EX_branch_target, ID_jump_target;
  logic [31:0] PC, IF_ID_instr, IF_ID_PC_plus_4, IF_ID_PC_plus_8;
  logic        IF_ID_valid;

  if_stage_if bus ();

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall_IF         (stall_IF),
    .flush_IF_ID      (flush_IF_ID),
    .EX_branch_taken  (EX_branch_taken),
    .EX_branch_target (EX_branch_target),
    .ID_jump          (ID_jump),
    .ID_jump_target   (ID_jump_target),
    .imem             (bus.master),
    .PC               (PC),
    .IF_ID_instr      (IF_ID_instr),
    .IF_ID_PC_plus_4  (IF_ID_PC_plus_4),
    .IF_ID_PC_plus_8  (IF_ID_PC_plus_8),
    .IF_ID_valid      (IF_ID_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic [31:0] p8;
    logic        valid;
    logic        full;
    logic [0:0]  st;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic rst_n, input logic rdy, input logic stl, input logic fl,
                       input logic ext, input logic [31:0] ext_t,
                       input logic jmp, input logic [31:0] jt, input logic [31:0] rdata);
    reset = rst_n; bus.imem_ready = rdy; stall_IF = stl; flush_IF_ID = fl;
    EX_branch_taken = ext; EX_branch_target = ext_t;
    ID_jump = jmp; ID_jump_target = jt; bus.imem_rdata = rdata;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] p4,
                      input logic [31:0] p8, input logic valid, input logic full, input logic [0:0] st);
    exp_t x;
    x.pc = pc; x.instr = instr; x.p4 = p4; x.p8 = p8; x.valid = valid; x.full = full; x.st = st;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int unsigned i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 1'b1, 32'h88, 32'hFFFF_FFFF);
      push(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, IDLE);
      tick();
      e = sb.pop_front();
      checks++; if (PC !== e.pc) begin errors++; $display("FAIL reset_pc got %h want %h", PC, e.pc); end
      checks++; if (IF_ID_instr !== e.instr) begin errors++; $display("FAIL reset_instr got %h want %h", IF_ID_instr, e.instr); end
      checks++; if (IF_ID_PC_plus_4 !== e.p4) begin errors++; $display("FAIL reset_p4 got %h want %h", IF_ID_PC_plus_4, e.p4); end
      checks++; if (IF_ID_PC_plus_8 !== e.p8) begin errors++; $display("FAIL reset_p8 got %h want %h", IF_ID_PC_plus_8, e.p8); end
      checks++; if (IF_ID_valid !== e.valid) begin errors++; $display("FAIL reset_valid got %b want %b", IF_ID_valid, e.valid); end
      checks++; if (dut.state !== e.st) begin errors++; $display("FAIL reset_state got %b want %b", dut.state, e.st); end
    end
  endtask

  // Straight-line fetches starting at pc; IF/ID captures each word with PC+4/PC+8.
  task automatic test_sequential(input logic [31:0] start, input int unsigned count);
    logic [31:0] pc = start;
    for (int unsigned i = 0; i < count; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8C00_0004 ^ pc);
      push(pc + 32'd4, 32'h8C00_0004 ^ pc, pc + 32'd4, pc + 32'd8, 1'b1, 1'b1, IDLE);
      pc = pc + 32'd4;
      tick();
      e = sb.pop_front();
      checks++; if (PC !== e.pc) begin errors++; $display("FAIL seq_pc got %h want %h", PC, e.pc); end
      checks++; if (bus.imem_addr !== e.pc) begin errors++; $display("FAIL seq_addr got %h want %h", bus.imem_addr, e.pc); end
      checks++; if (IF_ID_instr !== e.instr) begin errors++; $display("FAIL seq_instr got %h want %h", IF_ID_instr, e.instr); end
      checks++; if (IF_ID_PC_plus_4 !== e.p4) begin errors++; $display("FAIL seq_p4 got %h want %h", IF_ID_PC_plus_4, e.p4); end
      checks++; if (IF_ID_PC_plus_8 !== e.p8) begin errors++; $display("FAIL seq_p8 got %h want %h", IF_ID_PC_plus_8, e.p8); end
      checks++; if (IF_ID_valid !== e.valid) begin errors++; $display("FAIL seq_valid got %b want %b", IF_ID_valid, e.valid); end
    end
  endtask

  // PC=0x10 held for two stalled cycles; the ID jump seen during the stall is ignored.
  task automatic test_stall();
    for (int unsigned i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h900, 32'hDEAD_BEEF);
      push(32'h10, 32'h8C00_0004 ^ 32'hC, 32'h10, 32'h14, 1'b1, 1'b1, IDLE);
      tick();
      e = sb.pop_front();
      checks++; if (PC !== e.pc) begin errors++; $display("FAIL stall_pc got %h want %h", PC, e.pc); end
      checks++; if (IF_ID_instr !== e.instr) begin errors++; $display("FAIL stall_instr got %h want %h", IF_ID_instr, e.instr); end
      checks++; if (IF_ID_PC_plus_4 !== e.p4) begin errors++; $display("FAIL stall_p4 got %h want %h", IF_ID_PC_plus_4, e.p4); end
      checks++; if (IF_ID_PC_plus_8 !== e.p8) begin errors++; $display("FAIL stall_p8 got %h want %h", IF_ID_PC_plus_8, e.p8); end
      checks++; if (IF_ID_valid !== e.valid) begin errors++; $display("FAIL stall_valid got %b want %b", IF_ID_valid, e.valid); end
    end
  endtask

  // From PC=0x20: EX beats ID, then flush, then stall+flush, then an ID jump to 0x30.
  task automatic test_redirect_flush();
    for (int unsigned i = 0; i < 4; i++) begin
      case (i)
        0: begin
          drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 32'h1111_1111);
          push(32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, IDLE);
        end
        1: begin
          drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h2222_2222);
          push(32'h104, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, IDLE);
        end
        2: begin
          drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h3333_3333);
          push(32'h108, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, IDLE);
        end
        default: begin
          drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30, 32'h4444_4444);
          push(32'h30, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, IDLE);
        end
      endcase
      tick();
      e = sb.pop_front();
      checks++; if (PC !== e.pc) begin errors++; $display("FAIL redir_pc step %0d got %h want %h", i, PC, e.pc); end
      checks++; if (IF_ID_instr !== e.instr) begin errors++; $display("FAIL redir_instr step %0d got %h want %h", i, IF_ID_instr, e.instr); end
      checks++; if (IF_ID_valid !== e.valid) begin errors++; $display("FAIL redir_valid step %0d got %b want %b", i, IF_ID_valid, e.valid); end
    end
  endtask

  // PC=0x30 with a fetch outstanding: EX redirect, then ID overwrite, then ready.
  task automatic test_pend();
    for (int unsigned i = 0; i < 4; i++) begin
      case (i)
        0: begin
          drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 32'hBAD0_0000);
          push(32'h30, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, PEND);
        end
        1: begin
          drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 32'hBAD0_0001);
          push(32'h30, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, PEND);
        end
        2: begin
          drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hBAD0_0002);
          push(32'h500, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, IDLE);
        end
        default: begin
          drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0500_0500);
          push(32'h504, 32'h0500_0500, 32'h504, 32'h508, 1'b1, 1'b1, IDLE);
        end
      endcase
      tick();
      e = sb.pop_front();
      checks++; if (PC !== e.pc) begin errors++; $display("FAIL pend_pc step %0d got %h want %h", i, PC, e.pc); end
      checks++; if (IF_ID_instr !== e.instr) begin errors++; $display("FAIL pend_instr step %0d got %h want %h", i, IF_ID_instr, e.instr); end
      checks++; if (IF_ID_valid !== e.valid) begin errors++; $display("FAIL pend_valid step %0d got %b want %b", i, IF_ID_valid, e.valid); end
      checks++; if (dut.state !== e.st) begin errors++; $display("FAIL pend_state step %0d got %b want %b", i, dut.state, e.st); end
      if (e.full) begin
        checks++; if (IF_ID_PC_plus_4 !== e.p4) begin errors++; $display("FAIL pend_p4 got %h want %h", IF_ID_PC_plus_4, e.p4); end
        checks++; if (IF_ID_PC_plus_8 !== e.p8) begin errors++; $display("FAIL pend_p8 got %h want %h", IF_ID_PC_plus_8, e.p8); end
      end
    end
  endtask

  // Jump to 0xFFFFFFFC, fetch there (wrap), then an idle not-ready cycle bubbles.
  task automatic test_wrap();
    for (int unsigned i = 0; i < 3; i++) begin
      case (i)
        0: begin
          drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h5555_5555);
          push(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, IDLE);
        end
        1: begin
          drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h6666_6666);
          push(32'h0, 32'h6666_6666, 32'h0, 32'h4, 1'b1, 1'b1, IDLE);
        end
        default: begin
          drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h7777_7777);
          push(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, IDLE);
        end
      endcase
      tick();
      e = sb.pop_front();
      checks++; if (PC !== e.pc) begin errors++; $display("FAIL wrap_pc step %0d got %h want %h", i, PC, e.pc); end
      checks++; if (IF_ID_instr !== e.instr) begin errors++; $display("FAIL wrap_instr step %0d got %h want %h", i, IF_ID_instr, e.instr); end
      checks++; if (IF_ID_valid !== e.valid) begin errors++; $display("FAIL wrap_valid step %0d got %b want %b", i, IF_ID_valid, e.valid); end
      if (e.full) begin
        checks++; if (IF_ID_PC_plus_4 !== e.p4) begin errors++; $display("FAIL wrap_p4 got %h want %h", IF_ID_PC_plus_4, e.p4); end
        checks++; if (IF_ID_PC_plus_8 !== e.p8) begin errors++; $display("FAIL wrap_p8 got %h want %h", IF_ID_PC_plus_8, e.p8); end
      end
    end
  endtask

  // Reset mid-PEND drops the pending target; the next fetch starts at RESET_PC.
  task automatic test_reset_pend();
    for (int unsigned i = 0; i < 3; i++) begin
      case (i)
        0: begin
          drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 32'h0);
          push(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, PEND);
        end
        1: begin
          drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h9999_9999);
          push(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, IDLE);
        end
        default: begin
          drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hABCD_0000);
          push(32'h4, 32'hABCD_0000, 32'h4, 32'h8, 1'b1, 1'b1, IDLE);
        end
      endcase
      tick();
      e = sb.pop_front();
      checks++; if (PC !== e.pc) begin errors++; $display("FAIL rstpend_pc step %0d got %h want %h", i, PC, e.pc); end
      checks++; if (IF_ID_instr !== e.instr) begin errors++; $display("FAIL rstpend_instr step %0d got %h want %h", i, IF_ID_instr, e.instr); end
      checks++; if (IF_ID_valid !== e.valid) begin errors++; $display("FAIL rstpend_valid step %0d got %b want %b", i, IF_ID_valid, e.valid); end
      checks++; if (dut.state !== e.st) begin errors++; $display("FAIL rstpend_state step %0d got %b want %b", i, dut.state, e.st); end
      if (e.full) begin
        checks++; if (IF_ID_PC_plus_4 !== e.p4) begin errors++; $display("FAIL rstpend_p4 got %h want %h", IF_ID_PC_plus_4, e.p4); end
        checks++; if (IF_ID_PC_plus_8 !== e.p8) begin errors++; $display("FAIL rstpend_p8 got %h want %h", IF_ID_PC_plus_8, e.p8); end
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1;
    test_reset();
    test_sequential(32'h0, 4);
    test_stall();
    test_sequential(32'h10, 4);
    test_redirect_flush();
    test_pend();
    test_wrap();
    test_reset_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage plus IF/ID interstage register; directly upstream of the ID/EX register, which consumes IF_ID_PC_plus_4 and IF_ID_PC_plus_8.
- Owns the PC and drives the instruction-memory address.
- Applies EX branch/jr redirects and ID jump redirects, and supplies IF_ID_instr to decode.
- Honours hazard stall/flush and a memory-ready handshake; redirects that arrive while a fetch is outstanding are held in a pending-redirect FSM.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- stall_IF  in  1  hazard unit: hold PC and IF/ID (load-use).
- flush_IF_ID  in  1  hazard unit: bubble IF/ID on the next edge.
- EX_branch_taken  in  1  branch/jr resolved taken in EX.
- EX_branch_target  in  32  EX redirect target.
- ID_jump  in  1  j/jal decoded in ID.
- ID_jump_target  in  32  ID redirect target.
- imem_addr  out  32  fetch address; equals PC, combinational.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  fetch completes this cycle.
- PC  out  32  current fetch PC.
- IF_ID_instr  out  32  registered instruction.
- IF_ID_PC_plus_4  out  32  registered PC+4.
- IF_ID_PC_plus_8  out  32  registered PC+8, used for WB of link.
- IF_ID_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (reset==0 at a posedge) overrides everything:
  - PC=RESET_PC; IF_ID_instr=NOP_INSTR; IF_ID_PC_plus_4=0; IF_ID_PC_plus_8=0; IF_ID_valid=0; FSM=IDLE; pend_target=0.
  - A reset that arrives mid-PEND discards the pending target.
- Arithmetic: PC+4 and PC+8 are 32-bit, wrap modulo 2^32; there are no alignment checks.
- Redirect definitions:
  - redirect = EX_branch_taken | (ID_jump & ~stall_IF); an ID jump is ignored while stalled because it re-presents next cycle.
  - redir_target = EX_branch_target if EX_branch_taken, else ID_jump_target.
- FSM IDLE:
  - imem_ready=1 and redirect: PC<=redir_target; IF/ID<=bubble.
  - imem_ready=1, no redirect, flush_IF_ID: PC<=PC+4; IF/ID<=bubble.
  - imem_ready=1, no redirect, no flush, stall_IF: PC held; IF/ID held.
  - imem_ready=1, none of the above: PC<=PC+4; IF_ID_instr<=imem_rdata; IF_ID_PC_plus_4<=PC+4; IF_ID_PC_plus_8<=PC+8; IF_ID_valid<=1.
  - imem_ready=0 and redirect: PC held (address stable while the fetch is outstanding); pend_target<=redir_target; IF/ID<=bubble; next state PEND.
  - imem_ready=0, no redirect: PC held; IF/ID<=bubble unless stall_IF, which holds it.
- FSM PEND:
  - Any new redirect overwrites pend_target with redir_target; EX has priority over ID in the same cycle.
  - imem_ready=1: returned word is discarded; PC<=pend_target (or redir_target if a redirect arrives that same cycle); IF/ID<=bubble; next state IDLE. stall_IF does not delay this PC load.
  - imem_ready=0: PC held; remain in PEND.
- Priority: reset > EX redirect > ID redirect > flush_IF_ID > stall_IF > normal.
- A stall together with a flush yields a bubble.
- Latency: a taken redirect seen at edge N puts the target on imem_addr after N, with zero extra bubbles beyond the flushed slot when imem_ready stays high.

Decomposition:
- Shared package: RESET_PC and NOP_INSTR defaults, FSM state encoding IDLE=0/PEND=1, and the hazard-flag encoding normal=0/flush=1 shared with the ID/EX register.
- One natural sub-module: if_id_reg (IF/ID register with hold/bubble controls). PC, next-PC logic and the FSM live in if_stage.

Test Plan:
- Release reset with imem_ready=1 and imem_rdata=0x8C000004 -> after one edge IF_ID_instr=0x8C000004, IF_ID_PC_plus_4=0x4, IF_ID_PC_plus_8=0x8, valid=1, PC=0x4.
- PC=0x10; stall_IF=1 for 2 cycles -> PC stays 0x10 and IF/ID unchanged; an ID_jump asserted during the stall is ignored.
- PC=0x20; EX_branch_taken=1 and ID_jump=1 in the same cycle, targets 0x100/0x200 -> PC=0x100, IF_ID_valid=0.
- PC=0x30, imem_ready=0, EX redirect to 0x400, then an ID redirect to 0x500 one cycle later, then ready=1 -> PC holds 0x30 until ready, then PC=0x500, discarded word is not registered, FSM back to IDLE.
- PC=0xFFFFFFFC fetch -> IF_ID_PC_plus_4=0x0, IF_ID_PC_plus_8=0x4, PC=0x0.
- reset=0 asserted during PEND -> next edge PC=RESET_PC, FSM=IDLE, all IF_ID outputs 0.
